// File: rtl/simd_ctrl_pkg.sv
// Shared types for the simd_processor run controller.
package simd_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, PRIME, RUN, DONE} run_state_t;

   localparam logic CORE_RESET_ACTIVE = 1'b1;

endpackage

// File: rtl/simd_run_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + ONE;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/simd_run_ctrl.sv
// Run sequencer: streams a program into imem, runs the core, stops on halt-PC or timeout.
// Optional RUN_CTRL_CHECKSUM_EN adds a running sum of loaded words on load_checksum.
module simd_run_ctrl
   import simd_ctrl_pkg::*;
#(
   parameter int          ADDR_W     = 10,
   parameter logic [31:0] HALT_PC    = 32'h0000_0FFC,
   parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   input  logic [31:0]       pcF,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [31:0]       cycle_count,
`ifdef RUN_CTRL_CHECKSUM_EN
   output logic [31:0]       load_checksum,
`endif
   output logic [ADDR_W:0]   word_count
);

   localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0] WC_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   run_state_t r_state;
   run_state_t w_next;
   logic       w_hs;
   logic       w_clr;
   logic       w_halt;

   assign w_hs   = load_valid & load_ready;
   assign w_halt = (pcF == HALT_PC);

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_clr  = 1'b0;
      unique case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_next = LOAD;
               w_clr  = 1'b1;
            end
         end
         LOAD: begin
            // The capacity exit takes the word that fills the last slot.
            if (w_hs && (load_last || (word_count == LAST_IDX))) w_next = PRIME;
         end
         PRIME:   w_next = RUN;
         RUN: begin
            if (w_halt || (cycle_count == MAX_CYCLES - 32'd1)) w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         core_reset <= CORE_RESET_ACTIVE;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         word_count <= '0;
         timeout    <= 1'b0;
      end else begin
         load_ready <= (w_next == LOAD);
         busy       <= (w_next == LOAD) || (w_next == PRIME) || (w_next == RUN);
         done       <= (w_next == DONE);
         core_reset <= (w_next == RUN) ? ~CORE_RESET_ACTIVE : CORE_RESET_ACTIVE;
         imem_we    <= w_hs;
         if (w_hs) begin
            imem_addr  <= word_count[ADDR_W-1:0];
            imem_wdata <= load_data;
            word_count <= word_count + WC_ONE;
         end
         if (w_clr) begin
            word_count <= '0;
            timeout    <= 1'b0;
         end else if ((r_state == RUN) && (w_next == DONE)) begin
            timeout    <= ~w_halt;
         end
      end
   end

   sat_counter #(.WIDTH(32)) u_cycle_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (w_clr),
      .i_inc   (r_state == RUN),
      .o_count (cycle_count)
   );

`ifdef RUN_CTRL_CHECKSUM_EN
   logic [31:0] r_csum;

   always_ff @(posedge clk) begin
      if (reset || w_clr) r_csum <= '0;
      else if (w_hs)      r_csum <= r_csum + load_data;
   end

   assign load_checksum = r_csum;
`endif

endmodule
